// File: rtl/tri_pkg.sv
// tri_pkg: shared widths and types for the triangle area datapath
package tri_pkg;
    localparam int CW = 11;
    localparam int AW = 21;
    localparam int DW = 2*CW+3;
    typedef logic [0:CW-1] coord_t;
    typedef logic signed [DW-1:0] det_t;
endpackage

// File: rtl/tri_cross_term.sv
// tri_cross_term: one signed shoelace term x*(y1-y2), sign-extended to the det width
module tri_cross_term
    import tri_pkg::*;
(
    input  coord_t x,
    input  coord_t y1,
    input  coord_t y2,
    output det_t   term
);
    logic signed [CW:0]   d;
    logic signed [2*CW:0] p;
    assign d    = $signed({1'b0, y1}) - $signed({1'b0, y2});
    assign p    = $signed({1'b0, x}) * d;
    assign term = {{(DW-2*CW-1){p[2*CW]}}, p};
endmodule

// File: rtl/triangle_area.sv
// triangle_area: registered floor(|shoelace det|/2) of three 11-bit vertices
module triangle_area
    import tri_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [0:CW-1] ax,
    input  logic [0:CW-1] ay,
    input  logic [0:CW-1] bx,
    input  logic [0:CW-1] by,
    input  logic [0:CW-1] cx,
    input  logic [0:CW-1] cy,
    output logic [0:AW-1] area
);
    det_t t0, t1, t2, det;
    logic [DW-1:0] mag;
    logic unused_bits;
    tri_cross_term u_ta (.x(ax), .y1(by), .y2(cy), .term(t0));
    tri_cross_term u_tb (.x(bx), .y1(cy), .y2(ay), .term(t1));
    tri_cross_term u_tc (.x(cx), .y1(ay), .y2(by), .term(t2));
    assign det = t0 + t1 + t2;
    assign mag = det[DW-1] ? -det : det;
    // bit 0 is dropped by the halving; upper bits are provably zero for CW-bit inputs
    assign unused_bits = ^{mag[DW-1:AW+1], mag[0]};
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) area <= '0;
        else        area <= mag[AW:1];
endmodule

// File: tb/tb_triangle_area.sv
// tb_triangle_area: directed and randomized checks of triangle_area against a shoelace model
module tb_triangle_area;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [0:10] ax, ay, bx, by, cx, cy;
    logic [0:20] area;
    int compared = 0;
    int mismatched = 0;

    triangle_area dut (.clk(clk), .rst_n(rst_n), .ax(ax), .ay(ay), .bx(bx), .by(by),
                       .cx(cx), .cy(cy), .area(area));

    always #5 clk = ~clk;

    function automatic longint model(input longint a_x, a_y, b_x, b_y, c_x, c_y);
        longint det;
        det = a_x*(b_y-c_y) + b_x*(c_y-a_y) + c_x*(a_y-b_y);
        if (det < 0) det = -det;
        return det / 2;
    endfunction

    task automatic drive(input int a_x, a_y, b_x, b_y, c_x, c_y);
        ax = 11'(a_x); ay = 11'(a_y); bx = 11'(b_x);
        by = 11'(b_y); cx = 11'(c_x); cy = 11'(c_y);
    endtask

    task automatic check_tri(input string nm, input int a_x, a_y, b_x, b_y, c_x, c_y,
                             input longint exp_v);
        @(negedge clk);
        drive(a_x, a_y, b_x, b_y, c_x, c_y);
        @(negedge clk);
        compared++;
        if (area !== 21'(exp_v)) begin
            mismatched++;
            $display("FAIL %s: area=%0d expected=%0d", nm, area, exp_v);
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        drive(100, 200, 300, 5, 7, 900);
        repeat (3) @(negedge clk);
        compared++;
        if (area !== 21'd0) begin
            mismatched++;
            $display("FAIL reset_hold: area=%0d expected=0", area);
        end
        rst_n = 1;
        #1;
        compared++;
        if (area !== 21'd0) begin
            mismatched++;
            $display("FAIL reset_release: area=%0d expected=0", area);
        end
    endtask

    task automatic test_directed;
        check_tri("right_6",     0, 0, 4, 0, 0, 3, 6);
        check_tri("reversed_6",  0, 0, 0, 3, 4, 0, 6);
        check_tri("collinear",   0, 0, 1, 1, 2, 2, 0);
        check_tri("coincident",  5, 7, 5, 7, 5, 7, 0);
        check_tri("odd_det_1",   0, 0, 1, 0, 0, 1, 0);
        check_tri("odd_det_3",   0, 0, 3, 0, 0, 1, 1);
        check_tri("max_a",       0, 0, 2047, 0, 0, 2047, 2095104);
        check_tri("max_b",       2047, 2047, 0, 2047, 2047, 0, 2095104);
    endtask

    task automatic test_async_reset;
        check_tri("pre_async", 0, 0, 2047, 0, 0, 2047, 2095104);
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        compared++;
        if (area !== 21'd0) begin
            mismatched++;
            $display("FAIL async_reset: area=%0d expected=0", area);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_back_to_back;
        longint q[$];
        longint e;
        int v[6];
        for (int i = 0; i <= 50; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = q.pop_front();
                compared++;
                if (area !== 21'(e)) begin
                    mismatched++;
                    $display("FAIL back_to_back[%0d]: area=%0d expected=%0d", i-1, area, e);
                end
            end
            if (i < 50) begin
                for (int k = 0; k < 6; k++)
                    case ($urandom_range(0, 5))
                        0:       v[k] = 0;
                        1:       v[k] = 2047;
                        default: v[k] = int'($urandom_range(0, 2047));
                    endcase
                drive(v[0], v[1], v[2], v[3], v[4], v[5]);
                q.push_back(model(v[0], v[1], v[2], v[3], v[4], v[5]));
            end
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        test_reset;
        test_directed;
        test_async_reset;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
